// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_add_pkg;

    // Default operand/sum width in bits.
    localparam int DEFAULT_WIDTH = 8;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/serial_add_ctrl_full_adder_bit.sv
// Purely combinational 1-bit full-adder cell reused for every bit position.
module full_adder_bit (
    input  logic x_i,
    input  logic y_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    // Sum and carry of three input bits.
    always_comb begin
        sum_o  = x_i ^ y_i ^ cin_i;
        cout_o = (x_i & y_i) | (x_i & cin_i) | (y_i & cin_i);
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: sequences one full-adder cell LSB-first,
// one bit per clock, with the carry held in a flop between bits.
// Optional build macro: SERIAL_ADD_SUB_EN enables subtraction through sub_in.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    input  logic             sub_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    ctrl_state_t      state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] sum_out_q, sum_out_d;
    logic             cout_out_q, cout_out_d;

    logic             cellSum;
    logic             cellCout;

    // Operand B and carry seed chosen at the accept edge; subtraction
    // becomes A + ~B + 1 so the same cell serves both operations.
    logic [WIDTH-1:0] loadB;
    logic             loadCarry;
`ifdef SERIAL_ADD_SUB_EN
    assign loadB     = sub_in ? ~b_in : b_in;
    assign loadCarry = sub_in ? 1'b1 : cin_in;
`else
    logic unused_sub;
    assign unused_sub = sub_in;
    assign loadB      = b_in;
    assign loadCarry  = cin_in;
`endif

    full_adder_bit u_cell (
        .x_i   (a_sh_q[0]),
        .y_i   (b_sh_q[0]),
        .cin_i (carry_q),
        .sum_o (cellSum),
        .cout_o(cellCout)
    );

    // State, shift registers, carry, counter and held result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            sum_sh_q   <= '0;
            carry_q    <= 1'b0;
            bit_cnt_q  <= '0;
            sum_out_q  <= '0;
            cout_out_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_sh_q     <= a_sh_d;
            b_sh_q     <= b_sh_d;
            sum_sh_q   <= sum_sh_d;
            carry_q    <= carry_d;
            bit_cnt_q  <= bit_cnt_d;
            sum_out_q  <= sum_out_d;
            cout_out_q <= cout_out_d;
        end
    end

    // Next-state and datapath control; the visible result is latched only on
    // the final bit so it stays stable through RUN until a new one is ready.
    always_comb begin
        state_d    = state_q;
        a_sh_d     = a_sh_q;
        b_sh_d     = b_sh_q;
        sum_sh_d   = sum_sh_q;
        carry_d    = carry_q;
        bit_cnt_d  = bit_cnt_q;
        sum_out_d  = sum_out_q;
        cout_out_d = cout_out_q;
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    a_sh_d    = a_in;
                    b_sh_d    = loadB;
                    carry_d   = loadCarry;
                    bit_cnt_d = '0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                carry_d   = cellCout;
                sum_sh_d  = {cellSum, sum_sh_q[WIDTH-1:1]};
                a_sh_d    = a_sh_q >> 1;
                b_sh_d    = b_sh_q >> 1;
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (bit_cnt_q == LAST_BIT) begin
                    sum_out_d  = {cellSum, sum_sh_q[WIDTH-1:1]};
                    cout_out_d = cellCout;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign start_ready = (state_q == IDLE);
    assign res_valid   = (state_q == DONE);
    assign busy        = (state_q == RUN) || (state_q == DONE);
    assign sum_out     = sum_out_q;
    assign cout_out    = cout_out_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl (WIDTH=8), directed and random operations
// checked against an arithmetic reference model.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_valid = 1'b0;
    logic         start_ready;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         cin_in = 1'b0;
    logic         sub_in = 1'b0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] sum_out;
    logic         cout_out;
    logic         busy;

    int vectors = 0;
    int miscompares = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .a_in       (a_in),
        .b_in       (b_in),
        .cin_in     (cin_in),
        .sub_in     (sub_in),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .sum_out    (sum_out),
        .cout_out   (cout_out),
        .busy       (busy)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Reference result {cout, sum} from plain arithmetic.
    function automatic logic [W:0] refModel(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic cin, input logic sub);
        int total;
        total = int'(a) + int'(b) + int'(cin);
`ifdef SERIAL_ADD_SUB_EN
        if (sub) total = int'(a) + (255 - int'(b)) + 1;
`else
        if (sub) total = int'(a) + int'(b) + int'(cin);
`endif
        return total[W:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Presents one operand set and returns just after the accept edge,
    // then scrambles the inputs to prove they were captured.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
        @(negedge clk);
        a_in = a; b_in = b; cin_in = cin; sub_in = sub;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        a_in = ~a; b_in = ~b; cin_in = ~cin; sub_in = ~sub;
    endtask

    // Full operation: accept, measure latency, stall in DONE for 'stall'
    // cycles while offering new operands, then complete the handshake.
    task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub, input int stall);
        int cycles;
        logic [W:0] exp;
        exp = refModel(a, b, cin, sub);
        res_ready = 1'b0;
        vectors++;
        applyStimulus(a, b, cin, sub);
        @(negedge clk);
        cycles = 0;
        while (res_valid !== 1'b1 && cycles < 40) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end
        checkOutput("latency", 64'(cycles), 64'(W));
        checkOutput("sum", 64'(sum_out), 64'(exp[W-1:0]));
        checkOutput("cout", 64'(cout_out), 64'(exp[W]));
        checkOutput("busy_done", 64'(busy), 64'(1));
        checkOutput("start_ready_done", 64'(start_ready), 64'(0));
        for (int i = 0; i < stall; i++) begin
            start_valid = 1'b1;
            a_in = W'($urandom); b_in = W'($urandom); cin_in = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            checkOutput("stall_valid", 64'(res_valid), 64'(1));
            checkOutput("stall_sum", 64'(sum_out), 64'(exp[W-1:0]));
            checkOutput("stall_cout", 64'(cout_out), 64'(exp[W]));
            checkOutput("stall_start_ready", 64'(start_ready), 64'(0));
        end
        start_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        checkOutput("valid_after_hs", 64'(res_valid), 64'(0));
        checkOutput("start_ready_after_hs", 64'(start_ready), 64'(1));
        checkOutput("busy_after_hs", 64'(busy), 64'(0));
        checkOutput("sum_held_idle", 64'(sum_out), 64'(exp[W-1:0]));
        checkOutput("cout_held_idle", 64'(cout_out), 64'(exp[W]));
    endtask

    // Directed sequence followed by randomized operations.
    initial begin
        #2;
        checkOutput("rst_start_ready", 64'(start_ready), 64'(1));
        checkOutput("rst_res_valid", 64'(res_valid), 64'(0));
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_sum", 64'(sum_out), 64'(0));
        checkOutput("rst_cout", 64'(cout_out), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        runOp(8'h5A, 8'h33, 1'b0, 1'b0, 0);
        checkOutput("dir_5A_33", 64'(sum_out), 64'h8D);
        runOp(8'hFF, 8'h01, 1'b0, 1'b0, 0);
        checkOutput("dir_FF_01", 64'({cout_out, sum_out}), 64'h100);
        runOp(8'hFF, 8'hFF, 1'b1, 1'b0, 0);
        checkOutput("dir_FF_FF_1", 64'({cout_out, sum_out}), 64'h1FF);
        runOp(8'h12, 8'h34, 1'b1, 1'b0, 5);
        checkOutput("dir_backpressure", 64'(sum_out), 64'h47);

        // Abort mid-RUN once three bits have been processed.
        vectors++;
        applyStimulus(8'h77, 8'h11, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("abort_res_valid", 64'(res_valid), 64'(0));
        checkOutput("abort_busy", 64'(busy), 64'(0));
        checkOutput("abort_start_ready", 64'(start_ready), 64'(1));
        checkOutput("abort_sum", 64'(sum_out), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        runOp(8'h01, 8'h01, 1'b0, 1'b0, 0);
        checkOutput("after_abort", 64'({cout_out, sum_out}), 64'h002);

`ifdef SERIAL_ADD_SUB_EN
        runOp(8'h10, 8'h01, 1'b0, 1'b1, 0);
        checkOutput("sub_10_01", 64'({cout_out, sum_out}), 64'h10F);
        runOp(8'h00, 8'h01, 1'b1, 1'b1, 0);
        checkOutput("sub_00_01", 64'({cout_out, sum_out}), 64'h0FF);
`endif

        for (int n = 0; n < 24; n++) begin
            runOp(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder controller: accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake. It sequences a single 1-bit full-adder cell LSB-first, one bit per clock, keeping the carry in a flop between bits. It returns the WIDTH-bit sum and carry-out over a second valid/ready handshake. The block sits beside the full-adder cell and trades latency for area, so wide additions reuse one cell.

## Interface
- WIDTH, 8, operand/sum width in bits; legal range 2..64.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- start_valid  input  1  operands presented.
- start_ready  output  1  block can accept operands; high only in IDLE.
- a_in  input  WIDTH  operand A.
- b_in  input  WIDTH  operand B.
- cin_in  input  1  carry-in.
- sub_in  input  1  subtract request; ignored unless SERIAL_ADD_SUB_EN is defined.
- res_valid  output  1  result available; high only in DONE.
- res_ready  input  1  consumer accepts result.
- sum_out  output  WIDTH  result.
- cout_out  output  1  final carry (no-borrow in subtract mode).
- busy  output  1  high in RUN and DONE.

## Operation
- Reset: one clock, asynchronous active-high; on reset assertion (no clock required):
  - state to IDLE; a_sh, b_sh, sum_sh, carry and bit_cnt to 0.
  - Outputs: sum_out=0, cout_out=0, res_valid=0, busy=0; start_ready=1 (decoded from IDLE).
- States and transitions:
  - IDLE:
    - start_ready=1.
    - On start_valid&&start_ready: load a_sh<=a_in, b_sh<=b_in, carry<=cin_in, bit_cnt<=0; go to RUN.
  - RUN, once per cycle:
    - Cell inputs: x=a_sh[0], y=b_sh[0], Cin=carry.
    - carry<=cell Cout.
    - sum_sh<={cell Sum, sum_sh[WIDTH-1:1]}.
    - a_sh and b_sh shift right by 1; bit_cnt++.
    - When bit_cnt==WIDTH-1, the same edge moves to DONE.
  - DONE:
    - res_valid=1; sum_out=sum_sh; cout_out=carry.
    - Values held stable while res_ready is low.
    - On res_ready, go to IDLE.
- start_valid is ignored outside IDLE; no queuing.
- Operands are captured at the accept edge; later changes to a_in, b_in and cin_in have no effect.
- sum_out and cout_out keep the last result in IDLE until the next result is produced. They are registered; there is no combinational path from any input.
- bit_cnt width is $clog2(WIDTH). Arithmetic is modulo 2^WIDTH; the carry beyond the MSB appears only on cout_out.

## Timing
- Accept edge is T0. RUN occupies the WIDTH edges T1..TWIDTH. res_valid rises after edge TWIDTH.
- Latency: WIDTH cycles from accept edge to res_valid.
- With res_ready held high, the result handshake completes at edge T(WIDTH+1). start_ready is high after that edge, so the minimum initiation interval is WIDTH+2 cycles.
- Reset asserted mid-RUN or mid-DONE:
  - The operation is abandoned and no result is delivered.
  - res_valid drops asynchronously and all state clears.
  - After deassertion, the first accept is possible on the next edge.
- If res_valid and res_ready are high together, the handshake completes in that cycle.

## Configuration
- SERIAL_ADD_SUB_EN defined:
  - sub_in is captured at the accept edge.
  - If sub_in=1, b_sh loads ~b_in and carry loads 1; cin_in is ignored. Result = a_in − b_in mod 2^WIDTH; cout_out=1 means no borrow.
  - If sub_in=0, behaviour is identical to add.
- SERIAL_ADD_SUB_EN undefined:
  - sub_in is unconnected internally; add only.
  - No extra flops are generated.

## Structure
- Package serial_add_pkg:
  - state enum {IDLE, RUN, DONE} as a 2-bit typedef (ctrl_state_t).
  - Localparam for the default WIDTH.
- Sub-module full_adder_bit: purely combinational 1-bit cell (x, y, Cin -> Sum, Cout). It is instantiated once and is the only arithmetic in the block.
- The controller holds the FSM, shift registers, carry flop and counter.

## Test plan
- WIDTH=8; a_in=0x5A, b_in=0x33, cin_in=0 → res_valid 8 cycles after accept; sum_out=0x8D, cout_out=0.
- a_in=0xFF, b_in=0x01, cin_in=0 → sum_out=0x00, cout_out=1.
- a_in=0xFF, b_in=0xFF, cin_in=1 → sum_out=0xFF, cout_out=1.
- Backpressure: hold res_ready=0 for 5 cycles in DONE while pulsing start_valid with new operands → sum_out/cout_out stable, start_ready=0, new operands not taken. Next accept occurs only after the res_ready handshake.
- Reset asserted during RUN (bit_cnt=3) → res_valid=0, busy=0, start_ready=1 immediately. A following 0x01+0x01 yields 0x02, cout_out=0.
- SERIAL_ADD_SUB_EN defined: a_in=0x10, b_in=0x01, sub_in=1 → sum_out=0x0F, cout_out=1. With a_in=0x00, b_in=0x01, sub_in=1 → sum_out=0xFF, cout_out=0.
